// File: rtl/counter_pkg.sv
// Shared definitions for the bounded up/down counter and its sweep controller.
package counter_pkg;

  localparam int W_DEF  = 4;
  localparam int SW_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/sweep_ctrl.sv
// Sweep job sequencer: latches a job on start and drives load/enable/direction
// of a bounded counter, counting its terminal pulses until done or abort.
module sweep_ctrl
  import counter_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic          clk,
  input  logic          reset_p,
  input  logic          start,
  input  logic          abort,
  input  logic [W-1:0]  lo,
  input  logic [W-1:0]  hi,
  input  logic          dir_init,
  input  logic          mode,
  input  logic [SW-1:0] sweeps,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sweep_cnt,
  output logic          cnt_en,
  output logic          cnt_dir,
  output logic          cnt_ld,
  output logic [W-1:0]  cnt_a,
  output logic [W-1:0]  cnt_b,
  input  logic          cnt_carry
);

  logic [1:0]    state_q, state_d;
  logic          dir_q, dir_d;
  logic          mode_q, mode_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [SW-1:0] sweeps_q, sweeps_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    sweeps_d = sweeps_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (lo > hi) begin
            err_d = 1'b1;
          end else begin
            state_d  = ST_LOAD;
            lo_d     = lo;
            hi_d     = hi;
            mode_d   = mode;
            sweeps_d = sweeps;
            dir_d    = dir_init;
            cnt_d    = '0;
          end
        end
      end
      ST_LOAD: state_d = abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        // abort wins over a same-cycle carry, so the count does not advance
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_carry) begin
          cnt_d = cnt_q + 1'b1;
          if (sweeps_q != '0 && cnt_d == sweeps_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            if (mode_q) dir_d = ~dir_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_UP;
      mode_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      sweeps_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      mode_q   <= mode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      sweeps_q <= sweeps_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign sweep_cnt = cnt_q;
  assign cnt_en    = (state_q == ST_RUN);
  assign cnt_ld    = (state_q == ST_LOAD);
  assign cnt_dir   = dir_q;
  assign cnt_a     = lo_q;
  assign cnt_b     = hi_q;

endmodule
